// File: rtl/dvi_video_out.sv
// DVI output stage for a 12-bit dual-edge encoder: video timing at clk_100/2, 24-bit pixels split into two 12-bit words.
// One-entry holding register in front of the pixel consumer; empty slots emit UNDERFLOW_COLOR and bump deb.
module dvi_video_out #(
  parameter int          H_ACTIVE        = 640,
  parameter int          H_FP            = 16,
  parameter int          H_SYNC          = 96,
  parameter int          H_BP            = 48,
  parameter int          V_ACTIVE        = 480,
  parameter int          V_FP            = 10,
  parameter int          V_SYNC          = 2,
  parameter int          V_BP            = 33,
  parameter logic        HS_POL          = 1'b0,
  parameter logic        VS_POL          = 1'b0,
  parameter int          RST_CYCLES      = 16,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        ready,
  output logic        frame_start,
  output logic [11:0] DVI_D,
  output logic        DVI_DE,
  output logic        DVI_H,
  output logic        DVI_V,
  output logic        DVI_RESET_B,
  output logic        DVI_XCLK_P,
  output logic        DVI_XCLK_N,
  output logic [7:0]  deb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int RCW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  state_t          state, state_nxt;
  logic [RCW-1:0]  rst_cnt;
  logic            hold_done;
  logic            run;
  logic            ph;
  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;
  logic            h_last, v_last;
  logic            active, hs, vs;
  logic            hold_full;
  logic [23:0]     hold_dat;
  logic [23:0]     out_pix;
  logic [23:0]     pix_src;
  logic            transfer, consume;

  assign run       = (state == ST_RUN);
  assign hold_done = (int'(rst_cnt) == RST_CYCLES - 1);

  always_ff @(posedge clk_100) begin
    if (reset) state <= ST_HOLD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD: if (hold_done) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (reset || run)    rst_cnt <= '0;
    else if (!hold_done) rst_cnt <= rst_cnt + RCW'(1);
  end

  assign DVI_RESET_B = run;

  assign h_last = (int'(hcnt) == H_TOTAL - 1);
  assign v_last = (int'(vcnt) == V_TOTAL - 1);

  // Counters sit at zero through reset and the encoder hold so RUN starts at the frame origin.
  always_ff @(posedge clk_100) begin
    if (reset || !run) begin
      ph   <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      ph <= ~ph;
      if (ph) begin
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? '0 : vcnt + VW'(1);
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

  assign active = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
  assign hs     = (int'(hcnt) >= H_ACTIVE + H_FP) && (int'(hcnt) < H_ACTIVE + H_FP + H_SYNC);
  assign vs     = (int'(vcnt) >= V_ACTIVE + V_FP) && (int'(vcnt) < V_ACTIVE + V_FP + V_SYNC);

  assign ready    = run && !hold_full;
  assign transfer = pixel_valid && ready;
  assign consume  = run && !ph && active;
  assign pix_src  = hold_full ? hold_dat : UNDERFLOW_COLOR;

  // A transfer can only land while the register is empty, so it never races the consume-clear.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_dat  <= '0;
      out_pix   <= '0;
      deb       <= '0;
    end else begin
      if (transfer) begin
        hold_dat  <= pixel_data;
        hold_full <= 1'b1;
      end else if (consume && hold_full) begin
        hold_full <= 1'b0;
      end
      if (consume) begin
        out_pix <= pix_src;
        if (!hold_full && deb != 8'hFF) deb <= deb + 8'd1;
      end
    end
  end

  // Low word goes out straight from the consume source; out_pix supplies the high word next phase.
  always_ff @(posedge clk_100) begin
    if (reset || !run) begin
      DVI_D       <= '0;
      DVI_DE      <= 1'b0;
      DVI_H       <= ~HS_POL;
      DVI_V       <= ~VS_POL;
      DVI_XCLK_P  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (!active)  DVI_D <= '0;
      else if (ph)  DVI_D <= out_pix[23:12];
      else          DVI_D <= pix_src[11:0];
      DVI_DE      <= active;
      DVI_H       <= hs ? HS_POL : ~HS_POL;
      DVI_V       <= vs ? VS_POL : ~VS_POL;
      DVI_XCLK_P  <= ~ph;
      frame_start <= !ph && (hcnt == '0) && (vcnt == '0);
    end
  end

  assign DVI_XCLK_N = ~DVI_XCLK_P;

endmodule

// File: tb/tb_dvi_video_out.sv
// Directed bench for dvi_video_out on a shrunken 8x5-pixel timing (16 clocks per line, 80 per frame).
module tb_dvi_video_out;

  localparam logic [23:0] UND = 24'hC3A5F0;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        ready, frame_start;
  logic [11:0] DVI_D;
  logic        DVI_DE, DVI_H, DVI_V, DVI_RESET_B, DVI_XCLK_P, DVI_XCLK_N;
  logic [7:0]  deb;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          idx      = 0;
  int          mode     = 0;
  logic        last_acc = 1'b0;
  logic [23:0] q[$];

  dvi_video_out #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RST_CYCLES(4),
    .UNDERFLOW_COLOR(UND)
  ) dut (
    .clk_100(clk_100), .reset(reset),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .ready(ready), .frame_start(frame_start),
    .DVI_D(DVI_D), .DVI_DE(DVI_DE), .DVI_H(DVI_H), .DVI_V(DVI_V),
    .DVI_RESET_B(DVI_RESET_B), .DVI_XCLK_P(DVI_XCLK_P), .DVI_XCLK_N(DVI_XCLK_N),
    .deb(deb)
  );

  always #5 clk_100 = ~clk_100;

  // pix_of(0)=123456, pix_of(1)=ABCDEF, ...
  function automatic logic [23:0] pix_of(input int k);
    return 24'h123456 + 24'(k) * 24'h999999;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s @%0t got=%0h want=%0h", tag, $time, got, want);
    end
  endtask

  // mode 0: idle, 1: ordered stream, 2: data changes every cycle, 3: inputs left alone
  task automatic tick();
    logic        acc;
    logic [23:0] sent;
    case (mode)
      0: pixel_valid = 1'b0;
      1: begin pixel_valid = 1'b1; pixel_data = pix_of(idx); end
      2: begin pixel_valid = 1'b1; pixel_data = pix_of(200 + cyc); end
      default: ;
    endcase
    sent = pixel_data;
    acc  = pixel_valid && ready;
    @(posedge clk_100);
    #1;
    cyc++;
    last_acc = (acc === 1'b1);
    if (last_acc) begin
      if (mode == 1) idx++;
      if (mode == 2) q.push_back(sent);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    chk("rst_resetb", DVI_RESET_B, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_d", DVI_D, 0);
    chk("rst_de", DVI_DE, 0);
    chk("rst_h", DVI_H, 1);
    chk("rst_v", DVI_V, 1);
    chk("rst_xp", DVI_XCLK_P, 0);
    chk("rst_xn", DVI_XCLK_N, 1);
    chk("rst_deb", deb, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_resetb", DVI_RESET_B, 0);
      chk("hold_ready", ready, 0);
      chk("hold_xn", DVI_XCLK_N, 1);
      tick();
    end
    chk("run_resetb", DVI_RESET_B, 1);
    chk("run_ready", ready, 1);
    chk("run_fs_early", frame_start, 0);
    chk("run_de_early", DVI_DE, 0);
  endtask

  // kind 0: first frame after reset (slot 0 underflows, then pix_of order); else scoreboard/underflow
  task automatic run_frame(input int kind, input logic [7:0] want_deb);
    logic [23:0] cur;
    int pc, line, h, slot;
    logic act;
    cur = '0;
    for (int c = 0; c < 80; c++) begin
      tick();
      pc   = c % 16;
      line = c / 16;
      h    = pc / 2;
      act  = (h < 4) && (line < 2);
      if (act && (pc % 2 == 0)) begin
        slot = line * 4 + h;
        if (kind == 0) cur = (slot == 0) ? UND : pix_of(slot - 1);
        else           cur = (q.size() > 0) ? q.pop_front() : UND;
      end
      chk("de", DVI_DE, act);
      chk("hsync", DVI_H, !(pc >= 10 && pc < 14));
      chk("vsync", DVI_V, line != 3);
      chk("xclk_p", DVI_XCLK_P, pc % 2 == 0);
      chk("xclk_n", DVI_XCLK_N, pc % 2 != 0);
      chk("frame_start", frame_start, c == 0);
      chk("dvi_d", DVI_D, !act ? 12'h0 : (pc % 2 == 0) ? cur[11:0] : cur[23:12]);
      if (kind == 1 && last_acc) chk("ready_drop", ready, 0);
    end
    chk("deb", deb, want_deb);
  endtask

  initial begin
    reset       = 1'b0;
    pixel_valid = 1'b0;
    pixel_data  = '0;
    mode        = 1;
    do_reset();
    run_frame(0, 8'd1);

    // hold carries pix_of(7) across the frame boundary
    q.delete();
    q.push_back(pix_of(7));
    mode = 2;
    run_frame(1, 8'd1);

    mode = 0;
    run_frame(2, 8'd8);
    run_frame(2, 8'd16);
    repeat (29 * 80) tick();
    chk("deb_248", deb, 248);
    run_frame(2, 8'd255);
    run_frame(2, 8'd255);

    // park a pixel in hold during active line 1, then reset before it is consumed
    repeat (17) tick();
    mode        = 3;
    pixel_valid = 1'b1;
    pixel_data  = 24'h777777;
    chk("mid_ready_pre", ready, 1);
    tick();
    chk("mid_ready_full", ready, 0);
    pixel_valid = 1'b0;
    do_reset();
    q.delete();
    mode = 0;
    run_frame(2, 8'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
